instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_mem.sv | 38 +++
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package ifetch_pkg;

    localparam int          CODE_W  = 12;
    localparam int          ADDR_W  = 4;
    localparam logic [3:0]  HALT_OP = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Opcode lives in the top nibble of the instruction word.
    function automatic logic [3:0] opcode_of(input logic [CODE_W-1:0] word);
        return word[CODE_W-1 -: 4];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decoder handshake bus: instruction/pc out, ready and jump redirect back.
interface instr_fetch_if #(
    parameter int CODE_W = ifetch_pkg::CODE_W,
    parameter int ADDR_W = ifetch_pkg::ADDR_W
);
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code;
    logic [ADDR_W-1:0] pc;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;

    // Fetch unit side
    modport master (
        output code_valid, code, pc,
        input  code_ready, jmp_en, jmp_addr
    );

    // Decoder side
    modport slave (
        input  code_valid, code, pc,
        output code_ready, jmp_en, jmp_addr
    );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory: 2**ADDR_W words, synchronous write, registered read.
// Storage is never reset; only the read register is cleared so code reads 0 after reset.
module instr_mem #(
    parameter int CODE_W = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CODE_W-1:0] rdata
);
    logic [CODE_W-1:0] mem_q [2**ADDR_W];
    logic [CODE_W-1:0] rd_q;
    logic [CODE_W-1:0] rd_d;

    // Program write port (no reset: contents undefined until loaded)
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read data only changes on a read strobe, so it holds while the word is presented
    always_comb begin
        rd_d = rd_q;
        if (re) rd_d = mem_q[raddr];
    end

    // Read data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= rd_d;
    end

    assign rdata = rd_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program in IDLE, then fetches one word every
// two cycles and presents it to the decoder with a valid/ready handshake.
// Optional feature: define IFETCH_JUMP_EN to let jmp_en/jmp_addr redirect the pc
// on a handshake; otherwise those ports are ignored and pc always increments.
module instr_fetch #(
    parameter int         CODE_W  = ifetch_pkg::CODE_W,
    parameter int         ADDR_W  = ifetch_pkg::ADDR_W,
    parameter logic [3:0] HALT_OP = ifetch_pkg::HALT_OP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [CODE_W-1:0]    load_data,
    instr_fetch_if.master        dec,
    output logic                 halted,
    output logic [7:0]           instr_cnt
);
    import ifetch_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] rdata;
    logic [ADDR_W-1:0] pc_next;
    logic              hs;
    logic              is_halt;

    instr_mem #(
        .CODE_W (CODE_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (load_en && (state_q == IDLE)),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state_q == FETCH),
        .raddr (pc_q),
        .rdata (rdata)
    );

    assign hs      = (state_q == VALID) && dec.code_ready;
    assign is_halt = (rdata[CODE_W-1 -: 4] == HALT_OP);

`ifdef IFETCH_JUMP_EN
    assign pc_next = dec.jmp_en ? dec.jmp_addr : pc_q + ADDR_W'(1);
`else
    assign pc_next = pc_q + ADDR_W'(1);
    logic unused_jmp;
    assign unused_jmp = ^{dec.jmp_en, dec.jmp_addr};
`endif

    // Next-state, pc and counter update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                state_d = VALID;
            end
            VALID: begin
                if (hs) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (is_halt) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = run ? FETCH : IDLE;
                    end
                end
            end
            HALT: begin
                if (!run) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pc and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dec.code_valid = (state_q == VALID);
    assign dec.code       = rdata;
    assign dec.pc         = pc_q;
    assign halted         = (state_q == HALT);
    assign instr_cnt      = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed steps plus a randomized
// stretch, checked against a transaction-level model of memory, pc and count.
module tb_instr_fetch;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        halted;
    logic [7:0]  instr_cnt;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dec       (bus),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: program image, expected pc/count, halt flag
    logic [11:0] m_mem [16];
    int          m_pc;
    int          m_cnt;
    bit          m_halt;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake about to happen, advance the model, then
    // sample #1 after the edge and confirm a stalled word held still.
    task automatic cyc();
        logic        hs;
        logic        hold;
        logic [11:0] c0;
        logic [3:0]  p0;
        hs   = bus.code_valid && bus.code_ready;
        hold = bus.code_valid && !bus.code_ready;
        c0   = bus.code;
        p0   = bus.pc;
        if (hs) begin
            chk("hs_pc", bus.pc, m_pc);
            chk("hs_code", bus.code, m_mem[m_pc]);
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (m_mem[m_pc][11:8] == 4'hF) begin
                m_halt = 1'b1;
            end else begin
`ifdef IFETCH_JUMP_EN
                m_pc = bus.jmp_en ? int'(bus.jmp_addr) : (m_pc + 1) % 16;
`else
                m_pc = (m_pc + 1) % 16;
`endif
            end
        end else if (m_halt && !run) begin
            m_halt = 1'b0;
            m_pc   = 0;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_valid", bus.code_valid, 1);
            chk("hold_code", bus.code, c0);
            chk("hold_pc", bus.pc, p0);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        m_mem[a]  = d;
        cyc();
        load_en   = 1'b0;
    endtask

    initial begin
        logic [11:0] w;
        int          jexp;
        int          n;
        rst = 1'b0; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.code_ready = 1'b0; bus.jmp_en = 1'b0; bus.jmp_addr = '0;
        total = 0; bad = 0; m_pc = 0; m_cnt = 0; m_halt = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.code_valid, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_code", bus.code, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", instr_cnt, 0);
        rst = 1'b1;
        cyc();

        // Two-word program ending in halt
        load(4'd0, 12'h121);
        load(4'd1, 12'hF00);
        run = 1'b1; bus.code_ready = 1'b1;
        cyc();
        chk("fetch_valid0", bus.code_valid, 0);
        cyc();
        chk("w0_valid", bus.code_valid, 1);
        chk("w0_code", bus.code, 12'h121);
        chk("w0_pc", bus.pc, 0);
        cyc();
        chk("w0_after_valid", bus.code_valid, 0);
        chk("w0_after_pc", bus.pc, 1);
        cyc();
        chk("w1_code", bus.code, 12'hF00);
        cyc();
        chk("halt_halted", halted, 1);
        chk("halt_valid", bus.code_valid, 0);
        chk("halt_pc", bus.pc, 1);
        chk("halt_cnt", instr_cnt, 2);
        cyc();
        chk("halt_stay", halted, 1);
        run = 1'b0;
        cyc();
        chk("unhalt_halted", halted, 0);
        chk("unhalt_pc", bus.pc, 0);

        // Stall on the first word, then drop run and try a load while VALID
        run = 1'b1; bus.code_ready = 1'b0;
        cyc(); cyc();
        chk("stall_valid", bus.code_valid, 1);
        chk("stall_code", bus.code, 12'h121);
        repeat (5) cyc();
        chk("stall_cnt", instr_cnt, 2);
        run = 1'b0;
        load_en = 1'b1; load_addr = 4'd1; load_data = 12'h555;
        cyc();
        load_en = 1'b0;
        chk("rundrop_valid", bus.code_valid, 1);
        bus.code_ready = 1'b1;
        cyc();
        chk("idle_valid", bus.code_valid, 0);
        chk("idle_pc", bus.pc, 1);
        chk("idle_cnt", instr_cnt, 3);
        cyc();
        chk("idle_stays", bus.code_valid, 0);
        run = 1'b1;
        cyc(); cyc();
        chk("noload_code", bus.code, 12'hF00);
        cyc();
        chk("halt2", halted, 1);
        run = 1'b0;
        cyc();
        chk("halt2_exit_pc", bus.pc, 0);

        // 16 non-halt words; the last load (to pc) lands with run already high
        for (int i = 1; i < 16; i++) begin
            w = 12'($urandom_range(0, 12'hEFF));
            load(4'(i), w);
        end
        w = 12'($urandom_range(0, 12'hEFF));
        load_en = 1'b1; load_addr = 4'd0; load_data = w; m_mem[0] = w;
        run = 1'b1; bus.code_ready = 1'b1;
        cyc();
        load_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cyc();
            chk("wrap_valid", bus.code_valid, 1);
            chk("wrap_code", bus.code, m_mem[i % 16]);
            cyc();
            if (i == 15) chk("wrap_pc", bus.pc, 0);
        end

        // Jump offered on the handshake at pc=2
        cyc(); cyc(); cyc();
        chk("jmp_at_pc", bus.pc, 2);
        bus.jmp_en = 1'b1; bus.jmp_addr = 4'd9;
        cyc();
        bus.jmp_en = 1'b0;
        cyc();
`ifdef IFETCH_JUMP_EN
        jexp = 9;
`else
        jexp = 3;
`endif
        chk("jmp_pc", bus.pc, jexp);
        chk("jmp_code", bus.code, m_mem[jexp]);

        // Randomized ready and jump requests
        for (int i = 0; i < 400; i++) begin
            bus.code_ready = 1'($urandom_range(0, 1));
            bus.jmp_en     = 1'($urandom_range(0, 1));
            bus.jmp_addr   = 4'($urandom);
            cyc();
        end
        bus.jmp_en = 1'b0; run = 1'b0; bus.code_ready = 1'b1;
        repeat (4) cyc();
        chk("rand_valid", bus.code_valid, 0);
        chk("rand_pc", bus.pc, m_pc);
        chk("rand_cnt", instr_cnt, m_cnt);

        // Counter saturation
        run = 1'b1;
        repeat (540) cyc();
        chk("sat_cnt", instr_cnt, 255);
        chk("sat_model", instr_cnt, m_cnt);

        // Asynchronous reset in the middle of a handshake
        bus.code_ready = 1'b0;
        n = 0;
        while (!bus.code_valid && n < 4) begin
            cyc();
            n++;
        end
        chk("wait_valid", bus.code_valid, 1);
        bus.code_ready = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", bus.code_valid, 0);
        chk("arst_pc", bus.pc, 0);
        chk("arst_cnt", instr_cnt, 0);
        chk("arst_code", bus.code, 0);
        chk("arst_halted", halted, 0);
        @(posedge clk);
        #1;
        chk("arst_hold", bus.code_valid, 0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
